// File: rtl/vendas_pkg.sv
// Shared definitions for the vending controller: state and coin encodings,
// product codes, the price table, the credit limit and the timer width.
package vendas_pkg;

  localparam int unsigned ESTADO_W    = 2;
  localparam int unsigned CODIGO_W    = 4;
  localparam int unsigned CREDITO_W   = 4;
  localparam int unsigned MOEDA_W     = 2;
  localparam int unsigned TIMER_W     = 16;
  localparam int unsigned CREDITO_MAX = 8;

  // Values appear directly on the estado output.
  typedef enum logic [ESTADO_W-1:0] {
    ESPERA     = 2'b00,
    PRODUTO    = 2'b01,
    COMPARADOR = 2'b10,
    ENTREGA    = 2'b11
  } estado_e;

  typedef enum logic [MOEDA_W-1:0] {
    MOEDA_025       = 2'b00,
    MOEDA_050       = 2'b01,
    MOEDA_100       = 2'b10,
    MOEDA_RESERVADA = 2'b11
  } moeda_e;

  localparam logic [CODIGO_W-1:0] COD_0000     = 4'b0000;
  localparam logic [CODIGO_W-1:0] COD_0100     = 4'b0100;
  localparam logic [CODIGO_W-1:0] COD_0101     = 4'b0101;
  localparam logic [CODIGO_W-1:0] COD_1000     = 4'b1000;
  localparam logic [CODIGO_W-1:0] COD_1001     = 4'b1001;
  localparam logic [CODIGO_W-1:0] COD_1010     = 4'b1010;
  localparam logic [CODIGO_W-1:0] COD_1011     = 4'b1011;
  localparam logic [CODIGO_W-1:0] COD_1100     = 4'b1100;
  localparam logic [CODIGO_W-1:0] COD_1101     = 4'b1101;
  localparam logic [CODIGO_W-1:0] COD_INVALIDO = 4'b1111;

  // Price in R$0,25 units; 0 marks a code that is not on sale.
  function automatic logic [CREDITO_W-1:0] preco_de(input logic [CODIGO_W-1:0] codigo);
    logic [CREDITO_W-1:0] preco;
    case (codigo)
      COD_0000: preco = 4'd6;
      COD_0100: preco = 4'd5;
      COD_0101: preco = 4'd3;
      COD_1000: preco = 4'd4;
      COD_1001: preco = 4'd6;
      COD_1010: preco = 4'd7;
      COD_1011: preco = 4'd2;
      COD_1100: preco = 4'd8;
      COD_1101: preco = 4'd8;
      default:  preco = 4'd0;
    endcase
    return preco;
  endfunction

  function automatic logic codigo_valido(input logic [CODIGO_W-1:0] codigo);
    return preco_de(codigo) != 4'd0;
  endfunction

  // Coin value in R$0,25 units; the reserved code is worth nothing.
  function automatic logic [CREDITO_W-1:0] valor_moeda(input logic [MOEDA_W-1:0] tipo);
    logic [CREDITO_W-1:0] valor;
    case (tipo)
      MOEDA_025: valor = 4'd1;
      MOEDA_050: valor = 4'd2;
      MOEDA_100: valor = 4'd4;
      default:   valor = 4'd0;
    endcase
    return valor;
  endfunction

endpackage

// File: rtl/controle_vendas_temporizador.sv
// temporizador: loadable down-counter shared by all controller timeouts.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   carga_i   - load valor_i into the counter this cycle
//   valor_i   - number of cycles until done_o
//   done_o    - high during the valor_i-th cycle after the load edge
module temporizador
  import vendas_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         carga_i,
  input  logic [W-1:0] valor_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         done_q;

  // Reload wins over counting; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (carga_i) begin
      cnt_d = valor_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // done is registered from the next count so it is high while cnt_q == 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == W'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/controle_vendas.sv
// controle_vendas: vending machine controller (product selection, coin
// credit, change/refund and dispense).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   codigo_in         - product code from the keypad
//   confirmar         - confirm pulse
//   cancelar          - cancel pulse
//   moeda_valid       - coin strobe, moeda_tipo gives its type
//   estado            - state code for the display
//   produto           - latched product code (1111 = invalid)
//   valorMoedas       - credit in R$0,25 units
//   devolver          - overflow refund pending (display E405)
//   liberar           - dispense pulse
//   troco/troco_valid - change or refund amount and its strobe
//   moeda_rejeitada   - strobe for a coin that was not accepted
module controle_vendas
  import vendas_pkg::*;
#(
  parameter int unsigned TEMPO_ERRO    = 100,
  parameter int unsigned TEMPO_ENTREGA = 100,
  parameter int unsigned TEMPO_INATIVO = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] codigo_in,
  input  logic       confirmar,
  input  logic       cancelar,
  input  logic       moeda_valid,
  input  logic [1:0] moeda_tipo,
  output logic [1:0] estado,
  output logic [3:0] produto,
  output logic [3:0] valorMoedas,
  output logic       devolver,
  output logic       liberar,
  output logic [3:0] troco,
  output logic       troco_valid,
  output logic       moeda_rejeitada
);

  estado_e                state_q, state_d;
  logic [CODIGO_W-1:0]    produto_q, produto_d;
  logic [CREDITO_W-1:0]   valor_q, valor_d;
  logic                   devolver_q, devolver_d;
  logic                   liberar_q, liberar_d;
  logic [CREDITO_W-1:0]   troco_q, troco_d;
  logic                   troco_valid_q, troco_valid_d;
  logic                   rejeitada_q, rejeitada_d;

  logic                   timer_carga;
  logic [TIMER_W-1:0]     timer_valor;
  logic                   timer_done;

  logic [CREDITO_W-1:0]   preco_atual;
  logic [CREDITO_W:0]     soma;
  logic                   moeda_ok;
  logic                   comp_ativo;
  logic                   ev_cancela;
  logic                   ev_moeda;
  logic                   ev_excede;
  logic                   ev_venda;
  logic                   ev_inativo;
  logic                   ev_devolve;

  temporizador #(
    .W (TIMER_W)
  ) u_temporizador (
    .clk     (clk),
    .rst     (rst),
    .carga_i (timer_carga),
    .valor_i (timer_valor),
    .done_o  (timer_done)
  );

  // Events in COMPARADOR, by priority: cancel, then a coin of a valid type
  // (accepted or overflowing), then the sale check, then inactivity.
  // Because a coin outranks the sale check, a coin arriving on the cycle the
  // credit first reaches the price is still evaluated (and may overflow).
  assign preco_atual = preco_de(produto_q);
  assign soma        = {1'b0, valor_q} + {1'b0, valor_moeda(moeda_tipo)};
  assign moeda_ok    = moeda_valid && (moeda_tipo != MOEDA_RESERVADA);
  assign comp_ativo  = (state_q == COMPARADOR) && !devolver_q;
  assign ev_cancela  = comp_ativo && cancelar;
  assign ev_moeda    = comp_ativo && !cancelar && moeda_ok
                       && (soma <= (CREDITO_W+1)'(CREDITO_MAX));
  assign ev_excede   = comp_ativo && !cancelar && moeda_ok
                       && (soma > (CREDITO_W+1)'(CREDITO_MAX));
  assign ev_venda    = comp_ativo && !cancelar && !moeda_ok
                       && (valor_q >= preco_atual);
  assign ev_inativo  = comp_ativo && !cancelar && !moeda_ok
                       && (valor_q < preco_atual) && timer_done;
  assign ev_devolve  = (state_q == COMPARADOR) && devolver_q && timer_done;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ESPERA;
      produto_q     <= '0;
      valor_q       <= '0;
      devolver_q    <= 1'b0;
      liberar_q     <= 1'b0;
      troco_q       <= '0;
      troco_valid_q <= 1'b0;
      rejeitada_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      produto_q     <= produto_d;
      valor_q       <= valor_d;
      devolver_q    <= devolver_d;
      liberar_q     <= liberar_d;
      troco_q       <= troco_d;
      troco_valid_q <= troco_valid_d;
      rejeitada_q   <= rejeitada_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ESPERA: begin
        if (confirmar) begin
          state_d = PRODUTO;
        end
      end
      PRODUTO: begin
        // An invalid code only times out; buttons are ignored meanwhile.
        if (produto_q == COD_INVALIDO) begin
          if (timer_done) begin
            state_d = ESPERA;
          end
        end else if (cancelar) begin
          state_d = ESPERA;
        end else if (confirmar) begin
          state_d = COMPARADOR;
        end
      end
      COMPARADOR: begin
        if (ev_cancela || ev_inativo || ev_devolve) begin
          state_d = ESPERA;
        end else if (ev_venda) begin
          state_d = ENTREGA;
        end
      end
      ENTREGA: begin
        if (timer_done) begin
          state_d = ESPERA;
        end
      end
      default: state_d = ESPERA;
    endcase
  end

  // Output and timer-load logic.
  always_comb begin
    produto_d     = produto_q;
    valor_d       = valor_q;
    devolver_d    = devolver_q;
    liberar_d     = 1'b0;
    troco_d       = troco_q;
    troco_valid_d = 1'b0;
    rejeitada_d   = moeda_valid;
    timer_carga   = 1'b0;
    timer_valor   = '0;

    case (state_q)
      ESPERA: begin
        if (confirmar) begin
          produto_d   = codigo_valido(codigo_in) ? codigo_in : COD_INVALIDO;
          timer_carga = 1'b1;
          timer_valor = TIMER_W'(TEMPO_ERRO);
        end
      end
      PRODUTO: begin
        if ((produto_q != COD_INVALIDO) && !cancelar && confirmar) begin
          timer_carga = 1'b1;
          timer_valor = TIMER_W'(TEMPO_INATIVO);
        end
      end
      COMPARADOR: begin
        if (ev_moeda) begin
          valor_d     = soma[CREDITO_W-1:0];
          rejeitada_d = 1'b0;
          timer_carga = 1'b1;
          timer_valor = TIMER_W'(TEMPO_INATIVO);
        end
        if (ev_excede) begin
          devolver_d  = 1'b1;
          timer_carga = 1'b1;
          timer_valor = TIMER_W'(TEMPO_ERRO);
        end
        if (ev_venda) begin
          troco_d       = valor_q - preco_atual;
          troco_valid_d = 1'b1;
          liberar_d     = 1'b1;
          timer_carga   = 1'b1;
          timer_valor   = TIMER_W'(TEMPO_ENTREGA);
        end
        // Cancel, inactivity and overflow all refund the whole credit.
        if (ev_cancela || ev_inativo || ev_devolve) begin
          troco_d       = valor_q;
          troco_valid_d = 1'b1;
          valor_d       = '0;
          devolver_d    = 1'b0;
        end
      end
      ENTREGA: begin
        if (timer_done) begin
          valor_d   = '0;
          produto_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign estado          = state_q;
  assign produto         = produto_q;
  assign valorMoedas     = valor_q;
  assign devolver        = devolver_q;
  assign liberar         = liberar_q;
  assign troco           = troco_q;
  assign troco_valid     = troco_valid_q;
  assign moeda_rejeitada = rejeitada_q;

endmodule

// File: doc/controle_vendas.md
CONTROLE_VENDAS -- requirements
Module: controle_vendas

Interface
REQ-001 SHALL have parameter TEMPO_ERRO, default 100: cycles an error code (E404/E405) stays in place before returning to ESPERA.
REQ-002 SHALL have parameter TEMPO_ENTREGA, default 100: cycles spent in ENTREGA.
REQ-003 SHALL have parameter TEMPO_INATIVO, default 1000: cycles without a coin in COMPARADOR before an automatic cancel.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port codigo_in, input, 4 bits: product code from the keypad.
REQ-007 SHALL have port confirmar, input, 1 bit: single-cycle confirm pulse.
REQ-008 SHALL have port cancelar, input, 1 bit: single-cycle cancel pulse.
REQ-009 SHALL have port moeda_valid, input, 1 bit: single-cycle coin strobe.
REQ-010 SHALL have port moeda_tipo, input, 2 bits: coin type (00=R$0,25, 01=R$0,50, 10=R$1,00, 11=reserved).
REQ-011 SHALL have port estado, output, 2 bits: state code for the display driver.
REQ-012 SHALL have port produto, output, 4 bits: latched product code; 1111 means invalid.
REQ-013 SHALL have port valorMoedas, output, 4 bits: credit in R$0,25 units (0..8).
REQ-014 SHALL have port devolver, output, 1 bit: overflow or refund indication (display shows E405).
REQ-015 SHALL have port liberar, output, 1 bit: single-cycle dispense pulse.
REQ-016 SHALL have port troco, output, 4 bits: change or refund amount in R$0,25 units; valid while troco_valid is high.
REQ-017 SHALL have port troco_valid, output, 1 bit: single-cycle strobe for troco.
REQ-018 SHALL have port moeda_rejeitada, output, 1 bit: single-cycle strobe when a coin is not accepted.

Function
REQ-019 SHALL implement states ESPERA=00, PRODUTO=01, COMPARADOR=10, ENTREGA=11, driven directly on estado.
REQ-020 SHALL, in ESPERA on confirmar, latch codigo_in into produto and enter PRODUTO, substituting 1111 when the code is not in the price table.
REQ-021 SHALL use this price table, in units of R$0,25:
- 0000=6, 0100=5, 0101=3
- 1000=4, 1001=6, 1010=7, 1011=2
- 1100=8, 1101=8
REQ-022 SHALL, in PRODUTO with produto=1111, ignore confirmar and cancelar and return to ESPERA after TEMPO_ERRO cycles.
REQ-023 SHALL, in PRODUTO with a valid produto, enter COMPARADOR on confirmar and enter ESPERA on cancelar.
REQ-024 SHALL, in COMPARADOR on moeda_valid with a valid type, add 1, 2 or 4 to valorMoedas with a one-cycle update latency, and restart the inactivity timer.
REQ-025 SHALL reject a coin with moeda_tipo=11: valorMoedas unchanged, moeda_rejeitada pulses.
REQ-026 SHALL, on a coin that would raise valorMoedas above 8:
- leave valorMoedas unchanged and pulse moeda_rejeitada;
- set devolver;
- after TEMPO_ERRO cycles, pulse troco_valid with troco=valorMoedas, clear credit, clear devolver and enter ESPERA.
REQ-027 SHALL, on the cycle after valorMoedas>=price, enter ENTREGA and pulse troco_valid with troco=valorMoedas-price, even when that difference is 0.
REQ-028 SHALL, on cancelar or inactivity timeout in COMPARADOR, pulse troco_valid with troco=valorMoedas, clear credit and enter ESPERA.
REQ-029 SHALL give cancelar priority over a coin in the same cycle; that coin is rejected via moeda_rejeitada.
REQ-030 SHALL ignore confirmar in COMPARADOR, and ignore all inputs while devolver is set.
REQ-031 SHALL, in ENTREGA, pulse liberar on the first cycle, hold for TEMPO_ENTREGA cycles, then clear valorMoedas and produto and enter ESPERA.
REQ-032 SHALL, outside COMPARADOR, reject every coin via moeda_rejeitada.

Reset
REQ-033 SHALL, while rst is high at a clock edge, set:
- estado=ESPERA, produto=0000, valorMoedas=0;
- devolver=0, liberar=0, troco=0, troco_valid=0, moeda_rejeitada=0;
- timer cleared.
REQ-034 SHALL apply reset mid-operation (including in ENTREGA or during an error display) and discard the credit without pulsing troco_valid.

Structure
REQ-035 SHALL take the state encodings, product codes, price table, coin codes and credit limit (8) from a shared package vendas_pkg.
REQ-036 SHALL use one sub-module temporizador: a loadable down-counter with a done flag, shared by the TEMPO_ERRO, TEMPO_ENTREGA and TEMPO_INATIVO timeouts.

Verification
REQ-037 SHALL cover: code 1011 confirmed twice, then coins 00 and 00 -> ENTREGA one cycle after valorMoedas=2, troco=0 with troco_valid pulse, one liberar pulse, ESPERA after TEMPO_ENTREGA.
REQ-038 SHALL cover: code 0111 confirmed -> estado=01, produto=1111, return to ESPERA after TEMPO_ERRO, and further confirmar pulses during the error ignored.
REQ-039 SHALL cover: product 1100, coins 10, 10, 01 (credit 10 exceeds 8) -> third coin rejected, devolver=1, then troco=8 and ESPERA after TEMPO_ERRO.
REQ-040 SHALL cover: product 0000, coins 01 and 10 -> troco=0, since credit 6 equals price 6.
REQ-041 SHALL cover: product 1010, coin 10, then cancelar together with moeda_valid -> troco=4, moeda_rejeitada pulse, ESPERA.
REQ-042 SHALL cover: rst pulsed in COMPARADOR with valorMoedas=3 -> all outputs at reset values next cycle and no troco_valid pulse.
